seg7_msg_sequencer: RTL and testbench
=====================================

# seg7_msg_sequencer

Sequences a stored message of letter codes into the 7-segment letter decoder, one letter at a time, with a programmable dwell and an optional blank gap between letters. It sits between the top-level user inputs and the decoder. It owns a small writable message store, which resets to the default banner "ABDUL-JOSE", and a start/stop/loop controller. Downstream logic forces all segments off while `blank` is high.

## Interface
- `MSG_DEPTH`, default 16: number of message slots; power of two, at least 2.
- `DWELL`, default 12_000_000: clock cycles each letter is shown; at least 1.
- `GAP`, default 3_000_000: blank clock cycles after each letter; 0 disables the gap.
- `AW`, derived as $clog2(MSG_DEPTH): address width.

- `clk` in, 1 bit: only clock; all state on the rising edge.
- `rst` in, 1 bit: asynchronous, active-high reset.
- `start` in, 1 bit: level sampled each cycle; acted on only in IDLE.
- `stop` in, 1 bit: abort to IDLE; has priority over everything except reset.
- `loop_en` in, 1 bit: sampled at the end of the last letter; 1 restarts at slot 0.
- `msg_len` in, AW+1 bits: number of letters; captured on accepted start.
- `wr_en` in, 1 bit: message store write strobe.
- `wr_addr` in, AW bits: write slot.
- `wr_data` in, 4 bits: letter code. 0 A, 1 B, 2 D, 3 U, 4 L, 5 -, 6 J, 7 O, 8 S, 9 E; 10–15 display as blank.
- `letter` out, 4 bits: code presented to the decoder; always 0–9.
- `blank` out, 1 bit: 1 means display dark.
- `busy` out, 1 bit: high in SHOW or GAP.
- `done` out, 1 bit: one-cycle pulse when a non-looping pass completes.
- `pos` out, AW bits: current slot index.

## Operation
- **Reset values.**
  - Slots 0–9 reload 0..9 ("ABDUL-JOSE"); slots 10 and up reload 4'hF.
  - State IDLE, `letter`=0, `blank`=1, `busy`=0, `done`=0, `pos`=0, dwell counter 0, captured length 0.
- **States:** IDLE, SHOW, GAP.
- **IDLE → SHOW** on `start`=1, `stop`=0 and `msg_len`≠0.
  - Captured length = min(`msg_len`, MSG_DEPTH).
  - `pos`←0 and counter←0.
  - `start` with `msg_len`=0 is ignored.
- **SHOW**
  - `letter` = slot[`pos`] when that value is ≤9; otherwise `letter`=0 and `blank`=1.
  - Otherwise `blank`=0.
  - After DWELL cycles: go to GAP if GAP>0, else perform the advance directly.
- **GAP**
  - `blank`=1; `letter` holds its last value.
  - After GAP cycles, perform the advance.
- **Advance**
  - If `pos` < len−1: `pos`+1, enter SHOW.
  - Else if `loop_en`: `pos`←0, enter SHOW.
  - Else: enter IDLE, `pos`←0, pulse `done` on the IDLE-entry cycle.
- **Stop.** `stop` in SHOW or GAP: next cycle IDLE, `blank`=1, `pos`←0, no `done` pulse.
- **Start while busy** is ignored; `msg_len` changes while busy are ignored.
- **Writes**
  - Accepted in any state; the slot updates on the next edge.
  - The read path is combinational on `pos`, so a write to the displayed slot changes `letter` on the following cycle without restarting the dwell.
- **Reset mid-operation:** all outputs and the store return to reset values immediately; asynchronous.

## Timing
- Start latency: `start` sampled at edge N puts `busy`=1 with slot 0 on the outputs after edge N.
- Each letter occupies exactly DWELL + GAP cycles: DWELL cycles in SHOW, GAP cycles in GAP.
- A non-looping pass of L letters is L·(DWELL+GAP) cycles from the first SHOW cycle to the `done` cycle.
- `done` and `busy`=0 appear in the same cycle.
- Counter width is $clog2(max(DWELL,GAP)+1). The counter clears on every state entry, and terminal count is compared as count == limit−1.
- `pos` wraps only through the advance rule, never through modular overflow.
- Simultaneous `stop` and terminal count: `stop` wins, no `done`.
- Simultaneous `start` and `stop` in IDLE: the block stays in IDLE.

## Structure
- **Shared package `seg7_pkg`:**
  - Letter code constants `LTR_A`=0 … `LTR_E`=9 and `LTR_BLANK`=4'hF.
  - State enum (IDLE, SHOW, GAP).
  - Default-message function returning the reset content per slot.
  - The decoder imports the same constants.
- **Sub-module `msg_store`:**
  - MSG_DEPTH×4 register file.
  - Asynchronous reset to the default message.
  - One synchronous write port, one combinational read port.
- The top block contains the FSM, dwell counter and output registers.

## Test plan
All scenarios use DWELL=4, GAP=2, MSG_DEPTH=16.

- **Reset values:** assert `rst` mid-SHOW → same cycle `blank`=1, `busy`=0, `pos`=0; read-back shows slot 3 = 3 and slot 12 = 15.
- **Default pass:** `msg_len`=10, `loop_en`=0, `start` one cycle → `letter` sequence 0..9, each 4 cycles with `blank`=0 then 2 cycles with `blank`=1. `done` pulses once, 60 cycles after the first SHOW cycle.
- **Looping:** `msg_len`=3, `loop_en`=1 → `pos` 0,1,2,0,1 with no `done`. Drop `loop_en` during `pos`=2 → IDLE plus `done` after that letter's gap.
- **Stop mid-gap:** `stop` on the 1st GAP cycle of `pos`=4 → next cycle IDLE, `blank`=1, `pos`=0, `done`=0. A later `start` begins again at slot 0.
- **Live write:** during SHOW at `pos`=2, write slot 2 = 9 → `letter`=9 the next cycle, dwell still ends on schedule. Write slot 1 = 12, then run → slot 1 shows `blank`=1, `letter`=0.
- **Edge cases:**
  - `msg_len`=0 plus `start` → stays IDLE.
  - `msg_len`=20 → captured length 16, `pos` reaches 15.
  - `start` while busy → ignored.
  - GAP=0 build → letters back-to-back with `blank` never high during the run.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared letter codes, sequencer state encoding and the default banner
// used by the message sequencer and the 7-segment letter decoder.
package seg7_pkg;

    localparam logic [3:0] LTR_A     = 4'd0;
    localparam logic [3:0] LTR_B     = 4'd1;
    localparam logic [3:0] LTR_D     = 4'd2;
    localparam logic [3:0] LTR_U     = 4'd3;
    localparam logic [3:0] LTR_L     = 4'd4;
    localparam logic [3:0] LTR_DASH  = 4'd5;
    localparam logic [3:0] LTR_J     = 4'd6;
    localparam logic [3:0] LTR_O     = 4'd7;
    localparam logic [3:0] LTR_S     = 4'd8;
    localparam logic [3:0] LTR_E     = 4'd9;
    localparam logic [3:0] LTR_BLANK = 4'hF;

    // Highest code the decoder can render; anything above shows dark.
    localparam logic [3:0] LTR_MAX   = LTR_E;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Reset content of a message slot: "ABDUL-JOSE" then blanks.
    function automatic logic [3:0] default_msg(input int idx);
        if (idx >= 0 && idx <= 9) begin
            return 4'(idx);
        end
        return LTR_BLANK;
    endfunction

endpackage

// File: rtl/seg7_msg_sequencer_msg_store.sv
// Small message register file: resets to the default banner, one synchronous
// write port and one combinational read port.
module msg_store
    import seg7_pkg::*;
#(
    parameter int MSG_DEPTH = 16,
    parameter int AW        = $clog2(MSG_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [3:0]    rd_data
);

    logic [3:0] mem_q [MSG_DEPTH];
    logic [3:0] mem_d [MSG_DEPTH];

    always_comb begin
        for (int i = 0; i < MSG_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                mem_q[i] <= default_msg(i);
            end
        end else begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Combinational so a live write reaches the display one cycle later.
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/seg7_msg_sequencer.sv
// Steps through the stored message one letter at a time, showing each for
// DWELL cycles followed by an optional GAP of dark cycles.
module seg7_msg_sequencer
    import seg7_pkg::*;
#(
    parameter int MSG_DEPTH = 16,
    parameter int DWELL     = 12_000_000,
    parameter int GAP       = 3_000_000,
    parameter int AW        = $clog2(MSG_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [AW:0]   msg_len,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_data,
    output logic [3:0]    letter,
    output logic          blank,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pos
);

    localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] GAP_LAST   = (GAP > 0) ? CW'(GAP - 1) : '0;
    localparam logic [AW:0]   DEPTH_L    = (AW + 1)'(MSG_DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] pos_q, pos_d;
    logic [AW:0]   len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    letter_q, letter_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [3:0]    rd_data;
    logic          rd_ok;
    logic [3:0]    shown;
    logic          show_end;
    logic          gap_end;
    logic          advance;
    logic          is_last;

    msg_store #(
        .MSG_DEPTH (MSG_DEPTH),
        .AW        (AW)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (pos_q),
        .rd_data (rd_data)
    );

    assign rd_ok = (rd_data <= LTR_MAX);
    assign shown = rd_ok ? rd_data : LTR_A;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        len_d    = len_q;
        cnt_d    = cnt_q + CW'(1);
        letter_d = (state_q == ST_SHOW) ? shown : letter_q;
        done_d   = 1'b0;

        show_end = (state_q == ST_SHOW) && (cnt_q == DWELL_LAST);
        gap_end  = (state_q == ST_GAP) && (cnt_q == GAP_LAST);
        advance  = gap_end || (show_end && (GAP == 0));
        is_last  = !({1'b0, pos_q} < (len_q - (AW + 1)'(1)));

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start && !stop && (msg_len != '0)) begin
                    state_d = ST_SHOW;
                    pos_d   = '0;
                    len_d   = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
                end
            end
            ST_SHOW: begin
                if (show_end && (GAP > 0)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                state_d = ST_GAP;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (advance) begin
            cnt_d = '0;
            if (!is_last) begin
                pos_d   = pos_q + AW'(1);
                state_d = ST_SHOW;
            end else if (loop_en) begin
                pos_d   = '0;
                state_d = ST_SHOW;
            end else begin
                pos_d   = '0;
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end

        // Abort overrides a coincident terminal count, so no done pulse.
        if (stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            pos_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pos_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            letter_q <= LTR_A;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            letter_q <= letter_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // During GAP and IDLE the last shown code is held while the display is dark.
    assign letter = (state_q == ST_SHOW) ? shown : letter_q;
    assign blank  = !((state_q == ST_SHOW) && rd_ok);
    assign busy   = busy_q;
    assign done   = done_q;
    assign pos    = pos_q;

endmodule

// File: tb/tb_seg7_msg_sequencer.sv
// Scenario bench for seg7_msg_sequencer with DWELL=4, GAP=2 plus a GAP=0 build;
// per-cycle expectations are queued when stimulus is driven and compared as cycles elapse.
module tb_seg7_msg_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 4;
    localparam int GP    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW:0]   msg_len = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [3:0]    wr_data = '0;

    logic [3:0]    letter, letter_ng;
    logic          blank, blank_ng;
    logic          busy, busy_ng;
    logic          done, done_ng;
    logic [AW-1:0] pos, pos_ng;

    seg7_msg_sequencer #(.MSG_DEPTH(DEPTH), .DWELL(DW), .GAP(GP)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .msg_len(msg_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .letter(letter), .blank(blank), .busy(busy), .done(done), .pos(pos)
    );

    seg7_msg_sequencer #(.MSG_DEPTH(DEPTH), .DWELL(DW), .GAP(0)) dut_ng (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .msg_len(msg_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .letter(letter_ng), .blank(blank_ng), .busy(busy_ng), .done(done_ng), .pos(pos_ng)
    );

    always #5 clk = ~clk;

    // Observed vector layout: {letter[3:0], blank, pos[3:0], busy, done}
    logic [10:0] obs, obs_ng;
    assign obs    = {letter, blank, pos, busy, done};
    assign obs_ng = {letter_ng, blank_ng, pos_ng, busy_ng, done_ng};

    typedef struct packed {
        logic [10:0] v;
        logic [10:0] m;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    logic [3:0] model_mem [DEPTH];
    int         n_cmp  = 0;
    int         n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = (i <= 9) ? 4'(i) : 4'hF;
        end
    endtask

    task automatic push_exp(input logic [3:0] l, input logic b, input logic [3:0] p,
                            input logic bz, input logic d, input logic chk_letter);
        exp_t x;
        x.v = {l, b, p, bz, d};
        x.m = {(chk_letter ? 4'hF : 4'h0), 7'h7F};
        q.push_back(x);
    endtask

    // Expected cycles of a pass of n letters over a message of length len,
    // followed by the done cycle and one quiet idle cycle.
    task automatic gen_pass(input int n, input int len, input int gap);
        logic [3:0] v, sh;
        logic       bl;
        for (int i = 0; i < n; i++) begin
            v  = model_mem[i % len];
            sh = (v <= 4'd9) ? v : 4'd0;
            bl = (v > 4'd9);
            for (int c = 0; c < DW; c++) push_exp(sh, bl, 4'(i % len), 1'b1, 1'b0, 1'b1);
            for (int c = 0; c < gap; c++) push_exp(sh, 1'b1, 4'(i % len), 1'b1, 1'b0, 1'b1);
        end
        push_exp(4'd0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        push_exp(4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_start(input int len);
        msg_len = (AW + 1)'(len);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic do_write(input int addr, input logic [3:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic test_reset();
        tick();
        tick();
        rst = 1'b0;
        push_exp(4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        e = q.pop_front();
        n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin
            n_fail++;
            $display("FAIL reset_idle got=%h want=%h", obs & e.m, e.v & e.m);
        end
        do_write(3, 4'd7);
        do_write(12, 4'd2);
        do_start(10);
        for (int k = 0; k < 20; k++) tick();
        push_exp(4'd7, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1);
        e = q.pop_front();
        n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin
            n_fail++;
            $display("FAIL reset_preshow got=%h want=%h", obs & e.m, e.v & e.m);
        end
        #1 rst = 1'b1;
        #1;
        push_exp(4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        e = q.pop_front();
        n_cmp++;
        if ((obs & e.m) !== (e.v & e.m)) begin
            n_fail++;
            $display("FAIL reset_async got=%h want=%h", obs & e.m, e.v & e.m);
        end
        tick();
        rst = 1'b0;
        model_reset();
        $display("test_reset: done, compared=%0d", n_cmp);
    endtask

    task automatic test_default_pass();
        loop_en = 1'b0;
        gen_pass(10, 10, GP);
        do_start(10);
        for (int k = 0; q.size() > 0; k++) begin
            e = q.pop_front();
            n_cmp++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL default_pass cyc=%0d got=%h want=%h", k, obs & e.m, e.v & e.m);
            end
            tick();
        end
        $display("test_default_pass: done, compared=%0d", n_cmp);
    endtask

    task automatic test_looping();
        loop_en = 1'b1;
        gen_pass(6, 3, GP);
        do_start(3);
        for (int k = 0; q.size() > 0; k++) begin
            e = q.pop_front();
            n_cmp++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL looping cyc=%0d got=%h want=%h", k, obs & e.m, e.v & e.m);
            end
            if (k == 30) loop_en = 1'b0;
            tick();
        end
        $display("test_looping: done, compared=%0d", n_cmp);
    endtask

    task automatic test_stop_gap();
        gen_pass(10, 10, GP);
        do_start(10);
        for (int k = 0; k <= 28; k++) begin
            e = q.pop_front();
            n_cmp++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL stop_run cyc=%0d got=%h want=%h", k, obs & e.m, e.v & e.m);
            end
            if (k == 28) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        q.delete();
        for (int i = 0; i < 3; i++) push_exp(4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; q.size() > 0; k++) begin
            e = q.pop_front();
            n_cmp++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL stop_idle cyc=%0d got=%h want=%h", k, obs & e.m, e.v & e.m);
            end
            tick();
        end
        gen_pass(2, 2, GP);
        do_start(2);
        for (int k = 0; q.size() > 0; k++) begin
            e = q.pop_front();
            n_cmp++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL stop_restart cyc=%0d got=%h want=%h", k, obs & e.m, e.v & e.m);
            end
            tick();
        end
        $display("test_stop_gap: done, compared=%0d", n_cmp);
    endtask

    task automatic test_live_write();
        gen_pass(3, 3, GP);
        do_start(3);
        for (int k = 0; k <= 12; k++) begin
            e = q.pop_front();
            n_cmp++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL live_pre cyc=%0d got=%h want=%h", k, obs & e.m, e.v & e.m);
            end
            if (k == 12) begin
                wr_en   = 1'b1;
                wr_addr = 4'd2;
                wr_data = 4'd9;
            end
            tick();
        end
        wr_en = 1'b0;
        model_mem[2] = 4'd9;
        q.delete();
        for (int c = 0; c < DW - 1; c++) push_exp(4'd9, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < GP; c++) push_exp(4'd9, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1);
        push_exp(4'd0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        push_exp(4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 13; q.size() > 0; k++) begin
            e = q.pop_front();
            n_cmp++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL live_post cyc=%0d got=%h want=%h", k, obs & e.m, e.v & e.m);
            end
            tick();
        end
        do_write(1, 4'd12);
        gen_pass(3, 3, GP);
        do_start(3);
        for (int k = 0; q.size() > 0; k++) begin
            e = q.pop_front();
            n_cmp++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL live_blank_slot cyc=%0d got=%h want=%h", k, obs & e.m, e.v & e.m);
            end
            tick();
        end
        $display("test_live_write: done, compared=%0d", n_cmp);
    endtask

    task automatic test_edge_cases();
        for (int i = 0; i < 3; i++) push_exp(4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        do_start(0);
        for (int k = 0; q.size() > 0; k++) begin
            e = q.pop_front();
            n_cmp++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL len_zero cyc=%0d got=%h want=%h", k, obs & e.m, e.v & e.m);
            end
            tick();
        end
        // Oversized length clamps to 16; a start pulse mid-run must be ignored.
        gen_pass(16, 16, GP);
        do_start(20);
        for (int k = 0; q.size() > 0; k++) begin
            e = q.pop_front();
            n_cmp++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL len_clamp cyc=%0d got=%h want=%h", k, obs & e.m, e.v & e.m);
            end
            if (k == 30) begin
                start   = 1'b1;
                msg_len = 5'd3;
            end else if (k == 31) begin
                start   = 1'b0;
                msg_len = 5'd20;
            end
            tick();
        end
        $display("test_edge_cases: done, compared=%0d", n_cmp);
    endtask

    task automatic test_gap0();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        do_write(1, 4'd1);
        gen_pass(4, 4, 0);
        do_start(4);
        for (int k = 0; q.size() > 0; k++) begin
            e = q.pop_front();
            n_cmp++;
            if ((obs_ng & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL gap0 cyc=%0d got=%h want=%h", k, obs_ng & e.m, e.v & e.m);
            end
            tick();
        end
        $display("test_gap0: done, compared=%0d", n_cmp);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_pass();
        test_looping();
        test_stop_gap();
        test_live_write();
        test_edge_cases();
        test_gap0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
